seg_scan_driver: RTL and testbench

//  Receiving end of the 14-bit two-digit seven-segment bus ({tens[6:0], ones[6:0]}, active-low a..g, MSB=a)

---
 rtl/seg_scan_driver.sv | 122 ++++++++++++
 tb/tb_seg_scan_driver.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Two-digit seven-segment scan driver.
// Time-multiplexes a {tens, ones} active-low segment pair onto one shared
// segment bus with per-digit anode enables. Each digit slot opens with a
// ghost-blanking window; whole slots can be blanked by blink or by
// tens-zero suppression. The displayed pattern is latched only at the end
// of each frame so that an update never tears across the two digits.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 500,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] seg_in,
  input  logic        blink_en,
  input  logic        lz_blank,
  output logic [6:0]  seg_out,
  output logic [1:0]  an_out,
  output logic        frame_done
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_CYC);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_DARK = 7'h7F;
  localparam logic [6:0] ZERO_PAT = 7'b0000001;

  typedef enum logic {DIG_TENS, DIG_ONES} digit_e;
  typedef enum logic {PH_ON, PH_OFF} phase_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_e           digit_q, digit_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  phase_e           phase_q, phase_d;
  logic [13:0]      shadow_q, shadow_d;
  logic             slot_off_q, slot_off_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             fd_q, fd_d;

  logic slot_start;
  logic slot_last;
  logic capture;

  // Next-state: slot timing, blink timing, frame capture and output decode.
  always_comb begin
    slot_start = (cnt_q == '0);
    slot_last  = (cnt_q == SLOT_LAST);

    cnt_d   = slot_last ? '0 : cnt_q + 1'b1;
    digit_d = digit_q;
    if (slot_last) begin
      digit_d = (digit_q == DIG_TENS) ? DIG_ONES : DIG_TENS;
    end

    blk_cnt_d = blk_cnt_q + 1'b1;
    phase_d   = phase_q;
    if (blk_cnt_q == BLINK_LAST) begin
      blk_cnt_d = '0;
      phase_d   = (phase_q == PH_ON) ? PH_OFF : PH_ON;
    end

    capture  = slot_last && (digit_q == DIG_ONES);
    shadow_d = capture ? seg_in : shadow_q;
    fd_d     = capture;

    // Whole-slot blanking decision is taken at slot start and held for the
    // slot; at count 0 the fresh decision is used directly so BLANK_CYC=0
    // still honours it on the first cycle of the slot.
    slot_off_d = slot_off_q;
    if (slot_start) begin
      slot_off_d = ((digit_q == DIG_TENS) && lz_blank && (shadow_q[13:7] == ZERO_PAT))
                || (blink_en && (phase_q == PH_OFF));
    end

    seg_d = SEG_DARK;
    an_d  = 2'b11;
    if (!(cnt_q < BLANK_END) && !slot_off_d) begin
      if (digit_q == DIG_TENS) begin
        an_d  = 2'b10;
        seg_d = shadow_q[13:7];
      end else begin
        an_d  = 2'b01;
        seg_d = shadow_q[6:0];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      digit_q    <= DIG_TENS;
      blk_cnt_q  <= '0;
      phase_q    <= PH_ON;
      shadow_q   <= '1;
      slot_off_q <= 1'b0;
      seg_q      <= SEG_DARK;
      an_q       <= 2'b11;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      blk_cnt_q  <= blk_cnt_d;
      phase_q    <= phase_d;
      shadow_q   <= shadow_d;
      slot_off_q <= slot_off_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with a small refresh/blink configuration.
// A time-indexed reference model pushes the expected output of every cycle
// into a queue; a monitor pops and compares on the falling edge. Each
// scenario task also spot-checks a few cycles against hand-derived values.
module tb_seg_scan_driver;

  localparam int unsigned RD = 8;
  localparam int unsigned BC = 2;
  localparam int unsigned BD = 64;

  localparam logic [6:0] P0   = 7'b0000001;
  localparam logic [6:0] P1   = 7'b1001111;
  localparam logic [6:0] P2   = 7'b0010010;
  localparam logic [6:0] DARK = 7'h7F;

  logic        clk;
  logic        rst;
  logic [13:0] seg_in;
  logic        blink_en;
  logic        lz_blank;
  logic [6:0]  seg_out;
  logic [1:0]  an_out;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(
    .REFRESH_DIV(RD),
    .BLANK_CYC  (BC),
    .BLINK_DIV  (BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .blink_en  (blink_en),
    .lz_blank  (lz_blank),
    .seg_out   (seg_out),
    .an_out    (an_out),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: t counts cycles since reset release.
  logic [9:0]  exp_q[$];
  int unsigned t;
  logic [13:0] m_shadow;
  logic        m_off;

  always @(posedge clk or posedge rst) begin
    int unsigned pos;
    bit          tens;
    logic [9:0]  e;
    if (rst) begin
      t        = 0;
      m_shadow = 14'h3FFF;
      m_off    = 1'b0;
      exp_q.delete();
    end else begin
      pos  = t % RD;
      tens = ((t / RD) % 2) == 0;
      if (pos == 0)
        m_off = (tens && lz_blank && m_shadow[13:7] == P0) ||
                (blink_en && ((t / BD) % 2) == 1);
      if (pos < BC || m_off) e = {DARK, 2'b11, 1'b0};
      else if (tens)         e = {m_shadow[13:7], 2'b10, 1'b0};
      else                   e = {m_shadow[6:0], 2'b01, 1'b0};
      if (!tens && pos == RD - 1) begin
        e[0]     = 1'b1;
        m_shadow = seg_in;
      end
      exp_q.push_back(e);
      t++;
    end
  end

  // Scoreboard monitor plus the no-two-anodes invariant.
  always @(negedge clk) begin
    logic [9:0] e;
    if (an_out === 2'b00) begin
      errors++;
      $display("FAIL anode_overlap t=%0d an_out=%b required not 00", t, an_out);
    end
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({seg_out, an_out, frame_done} !== e) begin
        errors++;
        $display("FAIL scoreboard cycle=%0d got seg=%b an=%b fd=%b expected seg=%b an=%b fd=%b",
                 t - 1, seg_out, an_out, frame_done, e[9:3], e[2:1], e[0]);
      end
    end
  end

  task automatic start_run(input logic [13:0] pat, input logic lz, input logic blk);
    @(negedge clk);
    rst      = 1'b1;
    seg_in   = pat;
    lz_blank = lz;
    blink_en = blk;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    seg_in   = {P0, P1};
    lz_blank = 1'b0;
    blink_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({seg_out, an_out, frame_done} !== {DARK, 2'b11, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got seg=%b an=%b fd=%b expected 1111111 11 0",
               seg_out, an_out, frame_done);
    end
  endtask

  task automatic test_basic;
    start_run({P0, P1}, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 14 || i == 15) begin
        checks++;
        if (frame_done !== (i == 15)) begin
          errors++;
          $display("FAIL basic_frame_done cycle=%0d got %b expected %b", i, frame_done, i == 15);
        end
      end
      if (i == 4) begin
        checks++;
        if ({seg_out, an_out} !== {DARK, 2'b10}) begin
          errors++;
          $display("FAIL basic_first_frame_dark got seg=%b an=%b expected 1111111 10", seg_out, an_out);
        end
      end
      if (i == 17) begin
        checks++;
        if (an_out !== 2'b11) begin
          errors++;
          $display("FAIL basic_ghost_blank got an=%b expected 11", an_out);
        end
      end
      if (i == 20) begin
        checks++;
        if ({seg_out, an_out} !== {P0, 2'b10}) begin
          errors++;
          $display("FAIL basic_tens got seg=%b an=%b expected %b 10", seg_out, an_out, P0);
        end
      end
      if (i == 28) begin
        checks++;
        if ({seg_out, an_out} !== {P1, 2'b01}) begin
          errors++;
          $display("FAIL basic_ones got seg=%b an=%b expected %b 01", seg_out, an_out, P1);
        end
      end
    end
  endtask

  task automatic test_lz_blank;
    start_run({P0, P1}, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 20 || i == 36) begin
        checks++;
        if ({seg_out, an_out} !== {DARK, 2'b11}) begin
          errors++;
          $display("FAIL lz_tens_suppressed cycle=%0d got seg=%b an=%b expected 1111111 11",
                   i, seg_out, an_out);
        end
      end
      if (i == 28) begin
        checks++;
        if ({seg_out, an_out} !== {P1, 2'b01}) begin
          errors++;
          $display("FAIL lz_ones_kept got seg=%b an=%b expected %b 01", seg_out, an_out, P1);
        end
      end
    end
  endtask

  task automatic test_frame_update;
    start_run({P1, P2}, 1'b0, 1'b0);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (i == 20) begin
        checks++;
        if ({seg_out, an_out} !== {P1, 2'b10}) begin
          errors++;
          $display("FAIL update_tens_old got seg=%b an=%b expected %b 10", seg_out, an_out, P1);
        end
        seg_in = {P1, P1};
      end
      if (i == 28) begin
        checks++;
        if ({seg_out, an_out} !== {P2, 2'b01}) begin
          errors++;
          $display("FAIL update_no_tear got seg=%b an=%b expected %b 01", seg_out, an_out, P2);
        end
      end
      if (i == 44) begin
        checks++;
        if ({seg_out, an_out} !== {P1, 2'b01}) begin
          errors++;
          $display("FAIL update_new_ones got seg=%b an=%b expected %b 01", seg_out, an_out, P1);
        end
      end
    end
  endtask

  task automatic test_blink;
    start_run({P1, P0}, 1'b0, 1'b1);
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (i == 20) begin
        checks++;
        if ({seg_out, an_out} !== {P1, 2'b10}) begin
          errors++;
          $display("FAIL blink_on_phase got seg=%b an=%b expected %b 10", seg_out, an_out, P1);
        end
      end
      if (i == 68 || i == 124) begin
        checks++;
        if ({seg_out, an_out} !== {DARK, 2'b11}) begin
          errors++;
          $display("FAIL blink_off_phase cycle=%0d got seg=%b an=%b expected 1111111 11",
                   i, seg_out, an_out);
        end
      end
      if (i == 130) begin
        checks++;
        if ({seg_out, an_out} !== {P1, 2'b10}) begin
          errors++;
          $display("FAIL blink_wrap got seg=%b an=%b expected %b 10", seg_out, an_out, P1);
        end
      end
    end
  endtask

  task automatic test_blink_release;
    start_run({P1, P0}, 1'b0, 1'b1);
    for (int i = 0; i < 84; i++) begin
      @(negedge clk);
      if (i == 68) begin
        checks++;
        if (an_out !== 2'b11) begin
          errors++;
          $display("FAIL release_still_blank got an=%b expected 11", an_out);
        end
        blink_en = 1'b0;
      end
      if (i == 70) begin
        checks++;
        if (an_out !== 2'b11) begin
          errors++;
          $display("FAIL release_holds_slot got an=%b expected 11", an_out);
        end
      end
      if (i == 76) begin
        checks++;
        if ({seg_out, an_out} !== {P0, 2'b01}) begin
          errors++;
          $display("FAIL release_restored got seg=%b an=%b expected %b 01", seg_out, an_out, P0);
        end
      end
    end
  endtask

  task automatic test_midslot_reset;
    start_run({P0, P1}, 1'b0, 1'b0);
    repeat (29) @(negedge clk);
    checks++;
    if ({seg_out, an_out} !== {P1, 2'b01}) begin
      errors++;
      $display("FAIL midrst_pre got seg=%b an=%b expected %b 01", seg_out, an_out, P1);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({seg_out, an_out, frame_done} !== {DARK, 2'b11, 1'b0}) begin
      errors++;
      $display("FAIL midrst_async got seg=%b an=%b fd=%b expected 1111111 11 0",
               seg_out, an_out, frame_done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 20) begin
        checks++;
        if ({seg_out, an_out} !== {P0, 2'b10}) begin
          errors++;
          $display("FAIL midrst_restart got seg=%b an=%b expected %b 10", seg_out, an_out, P0);
        end
      end
    end
  endtask

  task automatic test_dark;
    start_run(14'h3FFF, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 20) begin
        checks++;
        if ({seg_out, an_out} !== {DARK, 2'b10}) begin
          errors++;
          $display("FAIL dark_tens got seg=%b an=%b expected 1111111 10", seg_out, an_out);
        end
      end
      if (i == 28) begin
        checks++;
        if ({seg_out, an_out} !== {DARK, 2'b01}) begin
          errors++;
          $display("FAIL dark_ones got seg=%b an=%b expected 1111111 01", seg_out, an_out);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz_blank();
    test_frame_update();
    test_blink();
    test_blink_release();
    test_midslot_reset();
    test_dark();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
